// File: rtl/hamming_sec_decoder.sv
// rtl/hamming_sec_decoder.sv - two-stage Hamming(12,8) SEC decoder with handshakes and error counters
module hamming_sec_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [11:0]      in_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_corrected,
    output logic             out_uncorr,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [3:0] syndrome(input logic [11:0] c);
        logic [3:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
        s[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
        return s;
    endfunction

    function automatic logic [7:0] extract(input logic [11:0] c);
        return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
    endfunction

    logic        s1_valid;
    logic [11:0] s1_code;
    logic [3:0]  s1_syn;
    logic        s1_adv;
    logic        xfer;
    logic [11:0] fixed_code;
    logic [7:0]  dec_data;
    logic        dec_corr;
    logic        dec_uncorr;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign xfer     = s1_valid && s1_adv;

    // Syndromes 13..15 point outside the codeword, so the raw word is passed through.
    always_comb begin
        fixed_code = s1_code;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        if (s1_syn >= 4'd13) begin
            dec_uncorr = 1'b1;
        end else if (s1_syn != 4'd0) begin
            dec_corr   = 1'b1;
            fixed_code = s1_code ^ (12'b1 << (s1_syn - 4'd1));
        end
        dec_data = extract(fixed_code);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_code  <= in_code;
            s1_syn   <= syndrome(in_code);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output payload only changes on a transfer, so it holds under back-pressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= dec_data;
                out_corrected <= dec_corr;
                out_uncorr    <= dec_uncorr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (xfer) begin
            if (dec_corr && corr_cnt != CNT_MAX) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
            if (dec_uncorr && uncorr_cnt != CNT_MAX) begin
                uncorr_cnt <= uncorr_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hamming_sec_decoder.sv
// tb/tb_hamming_sec_decoder.sv - directed vector bench for hamming_sec_decoder
module tb_hamming_sec_decoder;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [11:0]      in_code;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_corrected;
    logic             out_uncorr;
    logic             out_ready;
    logic             clr_cnt;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_sec_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_code      (in_code),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_corrected(out_corrected),
        .out_uncorr   (out_uncorr),
        .out_ready    (out_ready),
        .clr_cnt      (clr_cnt),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] code;
        logic [7:0]  data;
        logic        corr;
        logic        uncorr;
    } vec_t;

    vec_t tv[16];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_one(input logic [11:0] code, input logic [7:0] ed,
                            input logic ec, input logic eu);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = code;
        #1 chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("not_early", out_valid, 0);
        @(negedge clk);
        #1;
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, ed);
        chk("out_corrected", out_corrected, ec);
        chk("out_uncorr", out_uncorr, eu);
    endtask

    initial begin
        logic [11:0] base;
        logic [11:0] bp_codes[3];
        logic [7:0]  bp_exp[3];
        int          exp_corr;
        int          exp_unc;
        int          sent;
        int          rcv;

        base = 12'hA27;
        tv[0] = '{12'hA27, 8'hA5, 1'b0, 1'b0};
        tv[1] = '{12'h000, 8'h00, 1'b0, 1'b0};
        tv[2] = '{12'hA07, 8'hA5, 1'b1, 1'b0};
        for (int k = 0; k < 12; k++) tv[3+k] = '{base ^ (12'h1 << k), 8'hA5, 1'b1, 1'b0};
        tv[15] = '{12'h226, 8'h25, 1'b0, 1'b1};

        rst = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_corrected, out_uncorr}, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        exp_corr = 0;
        exp_unc  = 0;
        for (int i = 0; i < 16; i++) begin
            send_one(tv[i].code, tv[i].data, tv[i].corr, tv[i].uncorr);
            if (tv[i].corr && exp_corr < 3) exp_corr++;
            if (tv[i].uncorr && exp_unc < 3) exp_unc++;
            chk("corr_cnt", corr_cnt, exp_corr);
            chk("uncorr_cnt", uncorr_cnt, exp_unc);
        end

        // Counter saturation from a cleared state
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1 chk("clr_corr", corr_cnt, 0);
        chk("clr_uncorr", uncorr_cnt, 0);
        for (int i = 0; i < 5; i++) send_one(12'hA07, 8'hA5, 1'b1, 1'b0);
        chk("corr_saturate", corr_cnt, 3);

        // Clear coincides with a corrected transfer
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 12'hA07;
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1 chk("clr_prio_valid", out_valid, 1);
        chk("clr_prio_flag", out_corrected, 1);
        chk("clr_prio_cnt", corr_cnt, 0);

        // Back-pressure: out_ready low for the first 6 cycles
        bp_codes = '{12'hA27, 12'h000, 12'hA07};
        bp_exp   = '{8'hA5, 8'h00, 8'hA5};
        sent = 0;
        rcv  = 0;
        for (int i = 0; i < 40 && rcv < 3; i++) begin
            @(negedge clk);
            out_ready = (i >= 6);
            in_valid  = (sent < 3);
            in_code   = (sent < 3) ? bp_codes[sent] : 12'h000;
            #1;
            if (i >= 2 && i < 6) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, 8'hA5);
                chk("bp_accepts", sent, 2);
            end
            if (out_valid && out_ready) begin
                chk("bp_order", out_data, bp_exp[rcv]);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_received", rcv, 3);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("bp_no_dup", out_valid, 0);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 12'hA07;
        @(negedge clk);
        in_code   = 12'h226;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("full_in_ready", in_ready, 0);
        chk("full_cnt_nonzero", corr_cnt, 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_corr", corr_cnt, 0);
        chk("mid_rst_uncorr", uncorr_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("post_rst_idle", out_valid, 0);
        send_one(12'hA27, 8'hA5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_sec_decoder.md
# hamming_sec_decoder

Pipelined Hamming(12,8) single-error-correcting decoder with valid/ready handshakes and saturating error statistics. It sits in the transceiver receive path directly downstream of demodulation. It consumes 12-bit codewords in the same layout the encoder produces and delivers corrected 8-bit bytes to the UART transmit stage. It replaces a purely combinational decode so that back-pressure from the UART transmitter never drops a codeword.

## Interface
Parameters:
- CNT_W, 16, width of each error counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_code is valid this cycle
- in_code  in  12  codeword; in_code[k] is Hamming position k+1
- in_ready  out  1  decoder accepts in_code this cycle
- out_valid  out  1  out_data is valid
- out_data  out  8  corrected byte
- out_corrected  out  1  qualifies out_data: a single-bit error was fixed
- out_uncorr  out  1  qualifies out_data: syndrome was 13..15, data passed uncorrected
- out_ready  in  1  consumer accepts out_data this cycle
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of corrected words, saturating
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating

## Operation
- Codeword layout, even parity:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - p1 covers positions 1,3,5,7,9,11.
  - p2 covers 2,3,6,7,10,11.
  - p4 covers 4,5,6,7,12.
  - p8 covers 8,9,10,11,12.
- Syndrome s = {s8,s4,s2,s1}, each bit the XOR over its coverage set including its parity bit.
- Stage 1 (S1):
  - On handshake (in_valid && in_ready), register in_code and its 4-bit syndrome.
  - Set s1_valid.
- Stage 2 (S2, output register):
  - When S1 holds a word and S2 is empty or being drained, load from S1:
    - s = 0: data extracted unchanged, both flags 0.
    - s = 1..12: flip position s, then extract data; out_corrected = 1. This covers a flipped parity bit (s = 1,2,4,8), where the data is unchanged but the flag is still set.
    - s = 13..15: extract data from the raw codeword; out_uncorr = 1.
- Handshakes:
  - S1 advances when !out_valid || out_ready.
  - in_ready = !s1_valid || S1 advances. This is combinational from out_ready, with no combinational path from in_valid.
  - out_data, out_corrected and out_uncorr stay stable while out_valid && !out_ready.
- Counters:
  - Increment on the S1→S2 transfer according to the flag being loaded.
  - Each counter holds at 2^CNT_W−1 (no wrap).
  - clr_cnt has priority over increment: if a transfer and clr_cnt coincide, the counter ends at 0.
- Double-bit errors are not detected. They are miscorrected or reported as s = 13..15; this is accepted behaviour.

## Timing
- Reset values (rst low, asynchronous):
  - s1_valid = 0, out_valid = 0.
  - out_data = 0x00, out_corrected = 0, out_uncorr = 0.
  - corr_cnt = 0, uncorr_cnt = 0.
  - in_ready = 1.
- Latency: codeword accepted at edge N is presented with out_valid = 1 after edge N+1 (2-cycle latency).
- Throughput: 1 word/cycle while out_ready = 1.
- Full condition: S1 and S2 both hold words and out_ready = 0, which forces in_ready = 0.
- Capacity is 2 words. No word is lost or duplicated under any out_ready pattern.
- Reset mid-operation discards both stages. Counters return to 0. First output after release requires a new handshake.

## Test plan
- Clean word: in_code = 0xA27 → out_data = 0xA5, flags 0/0, 2 cycles after accept; counters unchanged. in_code = 0x000 → 0x00.
- Single data-bit error: in_code = 0xA07 (position 6 flipped) → out_data = 0xA5, out_corrected = 1, corr_cnt = 1. Repeat for each of the 12 positions of 0xA27: every case gives 0xA5 with out_corrected = 1.
- Uncorrectable syndrome: in_code = 0x226 (positions 1 and 12 flipped, s = 13) → out_data = 0x25, out_uncorr = 1, uncorr_cnt increments.
- Back-pressure: stream 0xA27, 0x000, 0xA07 with out_ready low for 5 cycles after the first accept.
  - in_ready drops after 2 accepts.
  - out_data holds 0xA5.
  - On release, outputs appear in order 0xA5, 0x00, 0xA5 with no loss.
- Counters: with CNT_W = 2, send 5 corrected words → corr_cnt sticks at 3. Assert clr_cnt on the same cycle as a corrected transfer → corr_cnt = 0.
- Reset mid-stream: drop rst while both stages are full → out_valid = 0, counters 0, in_ready = 1 immediately. After release, the next 0xA27 yields 0xA5.
